// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle logic/arithmetic/compare ops and iterative 1-bit/cycle shifts,
// with valid/ready handshakes on both the operand and result sides.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inValid,
    output logic             inReady,
    input  logic [3:0]       opControl,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegalOp
);
    localparam int unsigned SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_result, w_result_next;
    logic             r_illegal, w_illegal_next;
    logic [SHW-1:0]   r_cnt, w_cnt_next;
    logic [1:0]       r_kind, w_kind_next;

    logic [WIDTH-1:0] w_alu;
    logic             w_alu_illegal;
    logic             w_is_shift;
    logic             w_lt;
    logic [SHW-1:0]   w_amt;
    logic [WIDTH-1:0] w_shift_step;

    assign w_amt = opB[SHW-1:0];
    assign w_lt  = $signed(opA) < $signed(opB);

    always_comb begin
        w_alu         = '0;
        w_alu_illegal = 1'b0;
        w_is_shift    = 1'b0;
        case (opControl)
            4'b0000: w_alu = opA & opB;
            4'b0001: w_alu = opA | opB;
            4'b0011: w_alu = opA ^ opB;
            4'b0010: w_alu = opA + opB;
            4'b0110: w_alu = opA - opB;
            4'b0111: w_alu = {{(WIDTH-1){1'b0}}, w_lt};
            4'b1000, 4'b1001, 4'b1010: w_is_shift = 1'b1;
            default: w_alu_illegal = 1'b1;
        endcase
    end

    // Kind encoding reuses opControl[1:0]: 00 SLL, 01 SRL, 10 SRA.
    always_comb begin
        case (r_kind)
            2'b00:   w_shift_step = {r_result[WIDTH-2:0], 1'b0};
            2'b01:   w_shift_step = {1'b0, r_result[WIDTH-1:1]};
            default: w_shift_step = {r_result[WIDTH-1], r_result[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        w_state_next   = r_state;
        w_result_next  = r_result;
        w_illegal_next = r_illegal;
        w_cnt_next     = r_cnt;
        w_kind_next    = r_kind;
        case (r_state)
            StIdle: begin
                if (inValid) begin
                    if (w_is_shift) begin
                        w_result_next  = opA;
                        w_illegal_next = 1'b0;
                        w_cnt_next     = w_amt;
                        w_kind_next    = opControl[1:0];
                        w_state_next   = (w_amt == '0) ? StDone : StShift;
                    end else begin
                        w_result_next  = w_alu;
                        w_illegal_next = w_alu_illegal;
                        w_state_next   = StDone;
                    end
                end
            end
            StShift: begin
                w_result_next = w_shift_step;
                w_cnt_next    = r_cnt - 1'b1;
                if (r_cnt == SHW'(1)) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (outReady) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= StIdle;
            r_result  <= '0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
            r_kind    <= 2'b00;
        end else begin
            r_state   <= w_state_next;
            r_result  <= w_result_next;
            r_illegal <= w_illegal_next;
            r_cnt     <= w_cnt_next;
            r_kind    <= w_kind_next;
        end
    end

    assign inReady   = (r_state == StIdle);
    assign outValid  = (r_state == StDone);
    assign result    = r_result;
    assign zero      = (r_result == '0);
    assign illegalOp = r_illegal;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: arithmetic reference model checked every cycle, plus directed
// vectors carrying hand-computed results and latencies.
module tb_alu_exec_unit;
    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             inValid = 1'b0;
    logic             inReady;
    logic [3:0]       opControl = 4'h0;
    logic [WIDTH-1:0] opA = '0;
    logic [WIDTH-1:0] opB = '0;
    logic             outValid;
    logic             outReady = 1'b0;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegalOp;

    int n_tests = 0;
    int n_fail  = 0;

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .inValid   (inValid),
        .inReady   (inReady),
        .opControl (opControl),
        .opA       (opA),
        .opB       (opB),
        .outValid  (outValid),
        .outReady  (outReady),
        .result    (result),
        .zero      (zero),
        .illegalOp (illegalOp)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: whole-operation arithmetic plus a cycles-until-done count.
    function automatic logic [WIDTH-1:0] ref_res(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0011: return a ^ b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 1 : 0;
            4'b1000: return a << b[4:0];
            4'b1001: return a >> b[4:0];
            4'b1010: return $unsigned($signed(a) >>> b[4:0]);
            default: return '0;
        endcase
    endfunction

    function automatic logic ref_ill(input logic [3:0] op);
        return !(op inside {4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                            4'b1000, 4'b1001, 4'b1010});
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [WIDTH-1:0] b);
        if (op inside {4'b1000, 4'b1001, 4'b1010}) return int'(b[4:0]) + 1;
        return 1;
    endfunction

    logic             m_busy = 1'b0;
    logic             m_done = 1'b0;
    int               m_wait = 0;
    logic [WIDTH-1:0] m_res = '0;
    logic             m_ill = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_wait <= 0;
            m_res  <= '0;
            m_ill  <= 1'b0;
        end else if (m_done) begin
            if (outReady) m_done <= 1'b0;
        end else if (m_busy) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
            end
        end else if (inValid) begin
            m_res <= ref_res(opControl, opA, opB);
            m_ill <= ref_ill(opControl);
            if (ref_lat(opControl, opB) == 1) begin
                m_done <= 1'b1;
            end else begin
                m_busy <= 1'b1;
                m_wait <= ref_lat(opControl, opB) - 1;
            end
        end
    end

    // Result is only architecturally defined outside an in-progress shift.
    always @(negedge clk) begin
        if (!reset) begin
            check("cmp_inReady", 64'(inReady), 64'(!m_busy && !m_done));
            check("cmp_outValid", 64'(outValid), 64'(m_done));
            check("cmp_illegalOp", 64'(illegalOp), 64'(m_ill));
            if (!m_busy) begin
                check("cmp_result", 64'(result), 64'(m_res));
                check("cmp_zero", 64'(zero), 64'(m_res == '0));
            end
        end
    end

    task automatic run_op(input string nm, input logic [3:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp_r,
                          input int exp_lat, input logic exp_ill, input int stall);
        int cyc;
        check({nm, "_inReady_pre"}, 64'(inReady), 64'd1);
        opControl = op;
        opA       = a;
        opB       = b;
        inValid   = 1'b1;
        @(negedge clk);
        // Scramble operands and keep offering a bogus op: none of it may reach the op in flight.
        opA       = ~a;
        opB       = ~b;
        opControl = 4'b0010;
        cyc = 1;
        while (!outValid && cyc < 200) begin
            check({nm, "_inReady_busy"}, 64'(inReady), 64'd0);
            @(negedge clk);
            cyc++;
        end
        check({nm, "_latency"}, 64'(cyc), 64'(exp_lat));
        check({nm, "_result"}, 64'(result), 64'(exp_r));
        check({nm, "_zero"}, 64'(zero), 64'(exp_r == '0));
        check({nm, "_illegal"}, 64'(illegalOp), 64'(exp_ill));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({nm, "_stall_valid"}, 64'(outValid), 64'd1);
            check({nm, "_stall_result"}, 64'(result), 64'(exp_r));
            check({nm, "_stall_illegal"}, 64'(illegalOp), 64'(exp_ill));
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        check({nm, "_inReady_post"}, 64'(inReady), 64'd1);
        check({nm, "_outValid_post"}, 64'(outValid), 64'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_inReady", 64'(inReady), 64'd1);
        check("rst_outValid", 64'(outValid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_zero", 64'(zero), 64'd1);
        check("rst_illegal", 64'(illegalOp), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1, 1'b0, 0);
        run_op("sub_eq", 4'b0110, 32'd5, 32'd5, 32'h0, 1, 1'b0, 0);
        run_op("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'h1, 32'h1, 1, 1'b0, 0);
        run_op("slt_pos", 4'b0111, 32'h1, 32'hFFFF_FFFF, 32'h0, 1, 1'b0, 0);
        run_op("sub_wrap", 4'b0110, 32'h0, 32'h1, 32'hFFFF_FFFF, 1, 1'b0, 0);
        run_op("sra_31", 4'b1010, 32'h8000_0000, 32'hABCD_001F, 32'hFFFF_FFFF, 32, 1'b0, 0);
        run_op("sll_0", 4'b1000, 32'h0000_1234, 32'h0000_0100, 32'h0000_1234, 1, 1'b0, 0);
        run_op("sll_3", 4'b1000, 32'h0000_0001, 32'h0000_0003, 32'h0000_0008, 4, 1'b0, 0);
        run_op("srl_4", 4'b1001, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 5, 1'b0, 0);
        run_op("ill_f", 4'b1111, 32'h1234_5678, 32'h1, 32'h0, 1, 1'b1, 0);
        run_op("or", 4'b0001, 32'hF0, 32'h0F, 32'hFF, 1, 1'b0, 0);
        run_op("and", 4'b0000, 32'hF0, 32'h0F, 32'h0, 1, 1'b0, 0);
        run_op("ill_4", 4'b0100, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 1'b1, 0);
        run_op("xor_stall", 4'b0011, 32'hA5A5_0000, 32'h0000_5A5A, 32'hA5A5_5A5A, 1, 1'b0, 10);

        // Async reset while a 20-bit SLL has 7 steps left.
        opControl = 4'b1000;
        opA       = 32'h1;
        opB       = 32'd20;
        inValid   = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        repeat (13) @(negedge clk);
        check("mid_inReady", 64'(inReady), 64'd0);
        check("mid_outValid", 64'(outValid), 64'd0);
        #2 reset = 1'b1;
        #1;
        check("arst_inReady", 64'(inReady), 64'd1);
        check("arst_outValid", 64'(outValid), 64'd0);
        check("arst_result", 64'(result), 64'd0);
        check("arst_zero", 64'(zero), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_op("add_after_rst", 4'b0010, 32'd3, 32'd4, 32'd7, 1, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
